// File: rtl/falling_object_engine_pkg.sv
// ---------------------------------------------------------------------------
// falling_object_engine_pkg
//   Shared definitions for the catch-game falling-object engine: FSM state
//   encoding, fixed geometry constants and the per-slot colour table.
// ---------------------------------------------------------------------------
package falling_object_engine_pkg;

  // Game-update sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SPAWN  = 2'd2
  } fsm_state_t;

  // Paddle thickness in lines; a catch needs vertical overlap with this band
  localparam int PADDLE_H = 8;

  // Colour of each object slot (RGB888); the table covers the maximum of 8 slots
  function automatic logic [23:0] obj_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFF_00_00;
      3'd1:    c = 24'h00_FF_00;
      3'd2:    c = 24'h00_00_FF;
      3'd3:    c = 24'hFF_FF_00;
      3'd4:    c = 24'h00_FF_FF;
      3'd5:    c = 24'hFF_00_FF;
      3'd6:    c = 24'hFF_FF_FF;
      3'd7:    c = 24'hFF_80_00;
      default: c = 24'h00_00_00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/falling_object_engine_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
//   16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every clock. Supplies
//   pseudo-random spawn columns for the falling-object engine.
// Ports
//   vclock  in   1   clock
//   reset   in   1   asynchronous, active-high; loads seed
//   seed    in   16  reset value (a zero seed is replaced by 1 so the
//                    register can never lock up in the all-zero state)
//   q       out  16  current LFSR state
// ---------------------------------------------------------------------------
module lfsr16 (
  input  logic        vclock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;

  // Taps 16,14,13,11 map to bits 15,13,12,10
  assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

  // Shift register: seed on reset, one step per clock afterwards
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      r_q <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else begin
      r_q <= {r_q[14:0], w_fb};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/falling_object_engine.sv
// ---------------------------------------------------------------------------
// falling_object_engine
//   Game-logic stage between xvga and the video mux of the catch game. Holds
//   NUM_OBJ falling objects, moves them once per frame (on the falling edge of
//   vsync), detects catches against the paddle and misses at the screen
//   bottom, keeps score / miss count / game_over, and renders object pixels
//   with sync and blank delayed by one clock to stay aligned.
// Ports
//   vclock      in   1   pixel clock
//   reset       in   1   asynchronous, active-high
//   hcount      in   11  pixel column
//   vcount      in   10  pixel line
//   hsync       in   1   active low
//   vsync       in   1   active low; falling edge starts the frame update
//   blank       in   1   blanking interval
//   fall_speed  in   4   pixels per frame
//   paddle_x    in   11  paddle left edge
//   paddle_y    in   10  paddle top edge
//   paddle_w    in   8   paddle width
//   pixel       out  24  object colour at (hcount,vcount), 0 if none/blank
//   phsync      out  1   hsync delayed 1 clock
//   pvsync      out  1   vsync delayed 1 clock
//   pblank      out  1   blank delayed 1 clock
//   catch_pulse out  1   one clock per catch
//   miss_pulse  out  1   one clock per miss
//   score       out  8   catches, saturating
//   misses      out  4   misses, saturating
//   game_over   out  1   latched once misses reach MAX_MISS
// ---------------------------------------------------------------------------
module falling_object_engine
  import falling_object_engine_pkg::*;
#(
  parameter int          NUM_OBJ   = 4,
  parameter int          OBJ_SIZE  = 32,
  parameter int          SCREEN_H  = 768,
  parameter int          SPAWN_GAP = 60,
  parameter int          MAX_MISS  = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [3:0]  fall_speed,
  input  logic [10:0] paddle_x,
  input  logic [9:0]  paddle_y,
  input  logic [7:0]  paddle_w,
  output logic [23:0] pixel,
  output logic        phsync,
  output logic        pvsync,
  output logic        pblank,
  output logic        catch_pulse,
  output logic        miss_pulse,
  output logic [7:0]  score,
  output logic [3:0]  misses,
  output logic        game_over
);

  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

  // ---------------- state ----------------
  fsm_state_t       r_state;
  fsm_state_t       w_next_state;
  logic [IDX_W-1:0] r_idx;

  logic [NUM_OBJ-1:0] r_active;
  logic [10:0]        r_x [NUM_OBJ];
  logic [10:0]        r_y [NUM_OBJ];

  logic [7:0]  r_score;
  logic [3:0]  r_misses;
  logic        r_game_over;
  logic        r_catch_pulse;
  logic        r_miss_pulse;
  logic [7:0]  r_spawn_cnt;

  logic        r_vsync_d;
  logic        r_hsync_d;
  logic        r_blank_d;
  logic [23:0] r_pixel;

  // ---------------- LFSR ----------------
  logic [15:0] w_lfsr;
  logic        w_unused_lfsr;

  lfsr16 u_lfsr (
    .vclock (vclock),
    .reset  (reset),
    .seed   (LFSR_SEED),
    .q      (w_lfsr)
  );

  // Only bits [9:5] pick the spawn column
  assign w_unused_lfsr = ^{w_lfsr[15:10], w_lfsr[4:0]};

  // ---------------- frame tick ----------------
  logic w_tick;
  // r_vsync_d resets high so no spurious tick right after reset
  assign w_tick = r_vsync_d & ~vsync;

  // ---------------- current-slot move/catch/miss ----------------
  logic        w_cur_active;
  logic [10:0] w_cur_x;
  logic [10:0] w_cur_y;
  logic [10:0] w_ny;
  logic [11:0] w_ny_ext;
  logic [11:0] w_x_ext;
  logic        w_catch;
  logic        w_miss;
  logic        w_do_update;
  logic        w_do_spawn;

  assign w_cur_active = r_active[r_idx];
  assign w_cur_x      = r_x[r_idx];
  assign w_cur_y      = r_y[r_idx];
  assign w_ny         = w_cur_y + {7'b000_0000, fall_speed};
  // 12-bit compares so paddle_x+paddle_w and x+OBJ_SIZE cannot wrap
  assign w_ny_ext     = {1'b0, w_ny};
  assign w_x_ext      = {1'b0, w_cur_x};

  assign w_catch = w_cur_active
                && ((w_ny_ext + 12'(OBJ_SIZE)) > {2'b00, paddle_y})
                && (w_ny_ext < ({2'b00, paddle_y} + 12'(PADDLE_H)))
                && (w_x_ext < ({1'b0, paddle_x} + {4'b0000, paddle_w}))
                && ((w_x_ext + 12'(OBJ_SIZE)) > {1'b0, paddle_x});

  // Catch has priority over miss within the same slot
  assign w_miss = w_cur_active && !w_catch && (w_ny_ext >= 12'(SCREEN_H));

  // Once game_over latches, the remaining slots and the spawn are skipped
  assign w_do_update = (r_state == ST_UPDATE) && !r_game_over;
  assign w_do_spawn  = (r_state == ST_SPAWN)  && !r_game_over;

  // ---------------- spawn selection ----------------
  logic             w_free_found;
  logic [IDX_W-1:0] w_free_idx;
  logic [7:0]       w_cnt_inc;
  logic             w_spawn;

  // Lowest-index inactive slot (scan downward so the lowest index wins)
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end else begin
        w_free_found = w_free_found;
      end
    end
  end

  // Counter saturates at SPAWN_GAP so a blocked spawn retries every frame
  assign w_cnt_inc = (r_spawn_cnt >= 8'(SPAWN_GAP)) ? 8'(SPAWN_GAP) : (r_spawn_cnt + 8'd1);
  assign w_spawn   = w_do_spawn && (w_cnt_inc >= 8'(SPAWN_GAP)) && w_free_found;

  // ---------------- FSM ----------------
  // State register
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && !r_game_over) begin
          w_next_state = ST_UPDATE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        if (r_game_over) begin
          w_next_state = ST_IDLE;
        end else if (r_idx == LAST_IDX) begin
          w_next_state = ST_SPAWN;
        end else begin
          w_next_state = ST_UPDATE;
        end
      end
      ST_SPAWN: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Slot index walks 0..NUM_OBJ-1 during UPDATE, parked at 0 otherwise
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else if ((r_state == ST_UPDATE) && (r_idx != LAST_IDX)) begin
      r_idx <= r_idx + IDX_W'(1);
    end else if (r_state != ST_UPDATE) begin
      r_idx <= '0;
    end else begin
      r_idx <= r_idx;
    end
  end

  // ---------------- slot registers ----------------
  // Per-slot active/x/y: move or retire during UPDATE, fill during SPAWN
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      r_active <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        r_x[i] <= 11'd0;
        r_y[i] <= 11'd0;
      end
    end else if (w_do_update && w_cur_active) begin
      if (w_catch || w_miss) begin
        r_active[r_idx] <= 1'b0;
      end else begin
        r_y[r_idx] <= w_ny;
      end
    end else if (w_spawn) begin
      r_active[w_free_idx] <= 1'b1;
      r_y[w_free_idx]      <= 11'd0;
      // 32-aligned column 0..992
      r_x[w_free_idx]      <= {1'b0, w_lfsr[9:5], 5'b00000};
    end
  end

  // Spawn-gap counter, advanced once per completed frame update
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      r_spawn_cnt <= 8'd0;
    end else if (w_do_spawn) begin
      r_spawn_cnt <= w_spawn ? 8'd0 : w_cnt_inc;
    end
  end

  // ---------------- score / misses / game_over / pulses ----------------
  logic [3:0] w_misses_inc;
  assign w_misses_inc = (r_misses == 4'hF) ? 4'hF : (r_misses + 4'd1);

  // Counters and one-clock event pulses
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      r_score       <= 8'd0;
      r_misses      <= 4'd0;
      r_game_over   <= 1'b0;
      r_catch_pulse <= 1'b0;
      r_miss_pulse  <= 1'b0;
    end else begin
      r_catch_pulse <= 1'b0;
      r_miss_pulse  <= 1'b0;
      if (w_do_update && w_catch) begin
        r_score       <= (r_score == 8'hFF) ? 8'hFF : (r_score + 8'd1);
        r_catch_pulse <= 1'b1;
      end else if (w_do_update && w_miss) begin
        r_misses     <= w_misses_inc;
        r_miss_pulse <= 1'b1;
        if ({28'd0, w_misses_inc} >= 32'(MAX_MISS)) begin
          r_game_over <= 1'b1;
        end
      end
    end
  end

  // ---------------- render ----------------
  logic [23:0] w_hit_colour;

  // Hit test of every slot; scanning downward lets the lowest index win
  always_comb begin
    w_hit_colour = 24'h00_00_00;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (r_active[i]
          && ({1'b0, hcount} >= {1'b0, r_x[i]})
          && ({1'b0, hcount} < ({1'b0, r_x[i]} + 12'(OBJ_SIZE)))
          && ({2'b00, vcount} >= {1'b0, r_y[i]})
          && ({2'b00, vcount} < ({1'b0, r_y[i]} + 12'(OBJ_SIZE)))) begin
        w_hit_colour = obj_colour(3'(i));
      end else begin
        w_hit_colour = w_hit_colour;
      end
    end
  end

  // Pixel and delayed syncs share one pipeline stage
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      r_pixel   <= 24'h00_00_00;
      r_hsync_d <= 1'b1;
      r_vsync_d <= 1'b1;
      r_blank_d <= 1'b0;
    end else begin
      r_pixel   <= blank ? 24'h00_00_00 : w_hit_colour;
      r_hsync_d <= hsync;
      r_vsync_d <= vsync;
      r_blank_d <= blank;
    end
  end

  assign pixel       = r_pixel;
  assign phsync      = r_hsync_d;
  assign pvsync      = r_vsync_d;
  assign pblank      = r_blank_d;
  assign catch_pulse = r_catch_pulse;
  assign miss_pulse  = r_miss_pulse;
  assign score       = r_score;
  assign misses      = r_misses;
  assign game_over   = r_game_over;

endmodule

// File: tb/tb_falling_object_engine.sv
// ---------------------------------------------------------------------------
// tb_falling_object_engine
//   Randomised self-checking bench. A frame-level model (slot arrays, plain
//   integer arithmetic) predicts score, misses, game_over, pulse counts and
//   the rendered pixel at probe points around each object.
// ---------------------------------------------------------------------------
module tb_falling_object_engine;

  localparam int N = 4;

  logic        vclock = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank;
  logic [3:0]  fall_speed;
  logic [10:0] paddle_x;
  logic [9:0]  paddle_y;
  logic [7:0]  paddle_w;
  logic [23:0] pixel;
  logic        phsync, pvsync, pblank, catch_pulse, miss_pulse, game_over;
  logic [7:0]  score;
  logic [3:0]  misses;

  falling_object_engine dut (
    .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank), .fall_speed(fall_speed),
    .paddle_x(paddle_x), .paddle_y(paddle_y), .paddle_w(paddle_w),
    .pixel(pixel), .phsync(phsync), .pvsync(pvsync), .pblank(pblank),
    .catch_pulse(catch_pulse), .miss_pulse(miss_pulse), .score(score),
    .misses(misses), .game_over(game_over)
  );

  always #5 vclock = ~vclock;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference random source: 16-bit Fibonacci, taps 16,14,13,11
  logic [15:0] ref_lfsr;
  always @(posedge vclock or posedge reset) begin
    if (reset) ref_lfsr <= 16'hACE1;
    else       ref_lfsr <= {ref_lfsr[14:0], ^(ref_lfsr & 16'hB400)};
  end

  // Running pulse totals
  int tot_catch = 0;
  int tot_miss  = 0;
  always @(negedge vclock) begin
    if (catch_pulse === 1'b1) tot_catch <= tot_catch + 1;
    if (miss_pulse  === 1'b1) tot_miss  <= tot_miss + 1;
  end

  // ---------------- frame-level model ----------------
  logic [23:0] colours [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
                               24'h00FFFF, 24'hFF00FF, 24'hFFFFFF, 24'hFF8000};
  bit m_act [N];
  int m_x [N];
  int m_y [N];
  int m_score, m_miss, m_cnt;
  bit m_go;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_score = 0; m_miss = 0; m_cnt = 0; m_go = 0;
  endtask

  function automatic logic [23:0] exp_pixel(input int h, input int v, input bit b);
    if (b) return 24'h0;
    for (int i = 0; i < N; i++)
      if (m_act[i] && h >= m_x[i] && h < m_x[i] + 32 && v >= m_y[i] && v < m_y[i] + 32)
        return colours[i];
    return 24'h0;
  endfunction

  task automatic model_frame(input logic [15:0] rnd, output int ec, output int em);
    int fs, px, py, pw, ny, freei;
    ec = 0; em = 0;
    if (m_go) return;
    fs = int'(fall_speed); px = int'(paddle_x); py = int'(paddle_y); pw = int'(paddle_w);
    for (int i = 0; i < N; i++) begin
      if (m_go || !m_act[i]) continue;
      ny = m_y[i] + fs;
      if (ny + 32 > py && ny < py + 8 && m_x[i] < px + pw && m_x[i] + 32 > px) begin
        m_act[i] = 0; ec++;
        if (m_score < 255) m_score++;
      end else if (ny >= 768) begin
        m_act[i] = 0; em++;
        if (m_miss < 15) m_miss++;
        if (m_miss >= 5) m_go = 1;
      end else begin
        m_y[i] = ny;
      end
    end
    if (m_go) return;
    m_cnt++;
    if (m_cnt >= 60) begin
      freei = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_act[i]) freei = i;
      if (freei >= 0) begin
        m_act[freei] = 1; m_y[freei] = 0;
        m_x[freei] = int'(rnd[9:5]) * 32;
        m_cnt = 0;
      end else begin
        m_cnt = 60;
      end
    end
  endtask

  // ---------------- drivers ----------------
  // One render probe; entered and left on a falling edge
  task automatic probe(input int h, input int v, input bit b);
    logic hs;
    logic [23:0] e;
    hs = 1'($urandom);
    hcount = 11'(h); vcount = 10'(v); blank = b; hsync = hs;
    e = exp_pixel(h, v, b);
    @(negedge vclock);
    check_val("pixel", 32'(pixel), 32'(e));
    check_val("phsync", 32'(phsync), 32'(hs));
    check_val("pblank", 32'(pblank), 32'(b));
  endtask

  task automatic run_frame();
    int c0, m0, ec, em;
    logic [15:0] rnd;
    c0 = tot_catch; m0 = tot_miss;
    @(negedge vclock); vsync = 1'b0;
    @(posedge vclock);
    repeat (N) @(posedge vclock);
    #1 rnd = ref_lfsr;
    repeat (4) @(negedge vclock);
    vsync = 1'b1;
    model_frame(rnd, ec, em);
    @(negedge vclock);
    check_val("catch_pulses", 32'(tot_catch - c0), 32'(ec));
    check_val("miss_pulses", 32'(tot_miss - m0), 32'(em));
    check_val("score", 32'(score), 32'(m_score));
    check_val("misses", 32'(misses), 32'(m_miss));
    check_val("game_over", 32'(game_over), 32'(m_go));
    check_val("pvsync", 32'(pvsync), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        probe(m_x[i], m_y[i], 1'b0);
        probe(m_x[i] + 31, m_y[i] + 31, 1'b0);
        probe(m_x[i] + 32, m_y[i], 1'b0);
        if (m_y[i] > 0) probe(m_x[i], m_y[i] - 1, 1'b0);
        probe(m_x[i] + 5, m_y[i] + 5, 1'b1);
      end
    end
    probe($urandom_range(0, 1100), $urandom_range(0, 800), 1'($urandom));
  endtask

  task automatic do_reset();
    @(negedge vclock); reset = 1'b1;
    repeat (3) @(negedge vclock);
    model_reset();
    check_val("rst_pixel", 32'(pixel), 32'd0);
    check_val("rst_phsync", 32'(phsync), 32'd1);
    check_val("rst_pvsync", 32'(pvsync), 32'd1);
    check_val("rst_pblank", 32'(pblank), 32'd0);
    check_val("rst_score", 32'(score), 32'd0);
    check_val("rst_misses", 32'(misses), 32'd0);
    check_val("rst_game_over", 32'(game_over), 32'd0);
    check_val("rst_pulses", 32'({catch_pulse, miss_pulse}), 32'd0);
    reset = 1'b0;
    @(negedge vclock);
  endtask

  task automatic paddle_away();
    paddle_x = 11'd0; paddle_y = 10'd1000; paddle_w = 8'd8;
  endtask

  initial begin
    int k;
    reset = 1'b1; hcount = '0; vcount = '0; hsync = 1'b1; vsync = 1'b1; blank = 1'b0;
    fall_speed = 4'd0; paddle_away();
    do_reset();

    // Fill all slots with still objects; then hold with no free slot
    for (int f = 0; f < 310; f++) run_frame();
    check_val("all_slots_full", 32'(m_act[0] & m_act[1] & m_act[2] & m_act[3]), 32'd1);

    // Random play: paddle mostly placed under a live object
    for (int f = 0; f < 300 && !m_go; f++) begin
      fall_speed = 4'($urandom_range(0, 15));
      k = $urandom_range(0, N - 1);
      if (m_act[k] && $urandom_range(0, 9) < 8) begin
        paddle_x = 11'(m_x[k]); paddle_w = 8'd64; paddle_y = 10'($urandom_range(680, 760));
      end else begin
        paddle_x = 11'($urandom_range(0, 1023)); paddle_w = 8'($urandom);
        paddle_y = 10'($urandom_range(0, 1023));
      end
      run_frame();
    end

    // Force misses until game over, then confirm everything is frozen
    fall_speed = 4'd15; paddle_away();
    for (int f = 0; f < 400 && !m_go; f++) run_frame();
    check_val("game_over_reached", 32'(game_over), 32'd1);
    for (int f = 0; f < 10; f++) run_frame();

    do_reset();
    fall_speed = 4'd0;
    for (int f = 0; f < 61; f++) run_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
